// File: rtl/fp_pkg.sv
// fp_pkg: shared constants, state encoding and NaN helpers for the min/max reduction engine
package fp_pkg;
  localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
  localparam int FP_EXP_W = 8;
  localparam int FP_FRAC_W = 23;
  localparam logic OP_MIN = 1'b0;
  localparam logic OP_MAX = 1'b1;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
  function automatic logic is_nan(input logic [31:0] x);
    return (x[FP_FRAC_W +: FP_EXP_W] == '1) && (x[FP_FRAC_W-1:0] != '0);
  endfunction
  function automatic logic is_snan(input logic [31:0] x);
    return is_nan(x) && !x[FP_FRAC_W-1];
  endfunction
endpackage

// File: rtl/fp_minmax_reduce_if.sv
// fp_minmax_reduce_if: command, element stream and result ports; res_idx_o exists only with FP_REDUCE_ARGIDX_EN
interface fp_minmax_reduce_if #(parameter int LEN_W = 8);
  logic start_i;
  logic op_i;
  logic [LEN_W-1:0] len_i;
  logic busy_o;
  logic in_valid_i;
  logic in_ready_o;
  logic [31:0] in_data_i;
  logic res_valid_o;
  logic res_ready_i;
  logic [31:0] res_data_o;
  logic res_nv_o;
`ifdef FP_REDUCE_ARGIDX_EN
  logic [LEN_W-1:0] res_idx_o;
  modport master(output start_i, op_i, len_i, in_valid_i, in_data_i, res_ready_i,
                 input busy_o, in_ready_o, res_valid_o, res_data_o, res_nv_o, res_idx_o);
  modport slave(input start_i, op_i, len_i, in_valid_i, in_data_i, res_ready_i,
                output busy_o, in_ready_o, res_valid_o, res_data_o, res_nv_o, res_idx_o);
`else
  modport master(output start_i, op_i, len_i, in_valid_i, in_data_i, res_ready_i,
                 input busy_o, in_ready_o, res_valid_o, res_data_o, res_nv_o);
  modport slave(input start_i, op_i, len_i, in_valid_i, in_data_i, res_ready_i,
                output busy_o, in_ready_o, res_valid_o, res_data_o, res_nv_o);
`endif
endinterface

// File: rtl/fp_minmax_cmp.sv
// fp_minmax_cmp: RISC-V FMIN/FMAX selector; sel_b=1 when b strictly beats a (ties and NaN b keep a)
module fp_minmax_cmp
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        sel_b
);
  // sign-magnitude order, so -0.0 sorts below +0.0
  function automatic logic less(input logic [31:0] x, input logic [31:0] y);
    return (x[31] != y[31]) ? x[31] : x[31] ? (x[30:0] > y[30:0]) : (x[30:0] < y[30:0]);
  endfunction
  always_comb sel_b = is_nan(b) ? 1'b0 : is_nan(a) ? 1'b1 : (op == OP_MAX) ? less(a, b) : less(b, a);
endmodule

// File: rtl/fp_minmax_reduce.sv
// fp_minmax_reduce: streaming FMIN/FMAX reduction sequencer with NV flag
// Define FP_REDUCE_ARGIDX_EN to add res_idx_o, the position of the selected element.
module fp_minmax_reduce
  import fp_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input logic clk,
  input logic rst,
  fp_minmax_reduce_if.slave bus
);
  state_e state;
  logic op, nv, sel_b, take, last;
  logic [LEN_W-1:0] len, cnt;
  logic [31:0] acc, nxt;
`ifdef FP_REDUCE_ARGIDX_EN
  logic [LEN_W-1:0] idx;
  assign bus.res_idx_o = idx;
`endif
  fp_minmax_cmp u_cmp (.a(acc), .b(bus.in_data_i), .op(op), .sel_b(sel_b));
  always_comb begin
    take = (cnt == '0) || sel_b;
    nxt  = take ? bus.in_data_i : acc;
    last = cnt == LEN_W'(len - 1'b1);
  end
  assign bus.busy_o      = state != IDLE;
  assign bus.in_ready_o  = state == ACCUM;
  assign bus.res_valid_o = state == DONE;
  assign bus.res_data_o  = acc;
  assign bus.res_nv_o    = nv;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op    <= OP_MIN;
      len   <= '0;
      cnt   <= '0;
      acc   <= '0;
      nv    <= 1'b0;
`ifdef FP_REDUCE_ARGIDX_EN
      idx   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          op    <= bus.op_i;
          len   <= bus.len_i;
          cnt   <= '0;
          acc   <= FP_CANON_NAN;
          nv    <= 1'b0;
`ifdef FP_REDUCE_ARGIDX_EN
          idx   <= '0;
`endif
          state <= (bus.len_i != '0) ? ACCUM : DONE;
        end
        ACCUM: if (bus.in_valid_i) begin
          cnt <= cnt + 1'b1;
          // canonicalise on the final beat so DONE only ever presents the result
          acc <= (last && is_nan(nxt)) ? FP_CANON_NAN : nxt;
          nv  <= nv | is_snan(bus.in_data_i);
`ifdef FP_REDUCE_ARGIDX_EN
          if (take) idx <= cnt;
`endif
          if (last) state <= DONE;
        end
        DONE: if (bus.res_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
